fwd_hazard_unit: RTL and testbench

//  Parametrised forwarding and hazard unit for the 5-stage pipeline. Selects the per-operand EX bypass
//  (ID/EX, EX/MEM, MEM/WB) for NSRC source operands, detects load-use hazards, and tracks one

---
 rtl/fwd_hazard_unit.sv | 115 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit: EX operand bypass selects, load-use detection and a
// busy tracker for one multi-cycle MUL/DIV unit, driving the pipeline stall controls.
module fwd_hazard_unit #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NSRC   = 2,
  parameter int unsigned MD_LAT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NSRC*ADDR_W-1:0] IF_ID_Src,
  input  logic                   IF_ID_IsMD,
  input  logic [NSRC*ADDR_W-1:0] ID_EX_Src,
  input  logic [ADDR_W-1:0]      ID_EX_Rd,
  input  logic                   ID_EX_MemRead,
  input  logic [ADDR_W-1:0]      EX_MEM_Rd,
  input  logic                   EX_MEM_RegWrite,
  input  logic [ADDR_W-1:0]      MEM_WB_Rd,
  input  logic                   MEM_WB_RegWrite,
  input  logic                   md_start,
  input  logic [ADDR_W-1:0]      md_rd,
  output logic [NSRC*2-1:0]      Forward,
  output logic                   stall,
  output logic                   PC_Write,
  output logic                   IF_ID_Write,
  output logic                   ID_EX_Flush,
  output logic                   md_busy,
  output logic                   md_wb
);

  localparam int unsigned CntW = $clog2(MD_LAT + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} md_state_e;

  md_state_e         state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] rd_q, rd_d;

  logic luh, mdh, md_rd_hit;

  // EX/MEM has priority over MEM/WB since it holds the younger result.
  always_comb begin
    Forward = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (EX_MEM_RegWrite && (EX_MEM_Rd != '0) &&
          (EX_MEM_Rd == ID_EX_Src[k*ADDR_W +: ADDR_W])) begin
        Forward[2*k +: 2] = 2'b10;
      end else if (MEM_WB_RegWrite && (MEM_WB_Rd != '0) &&
                   (MEM_WB_Rd == ID_EX_Src[k*ADDR_W +: ADDR_W])) begin
        Forward[2*k +: 2] = 2'b01;
      end
    end
  end

  always_comb begin
    luh       = 1'b0;
    md_rd_hit = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (ID_EX_MemRead && (ID_EX_Rd != '0) && (ID_EX_Rd == IF_ID_Src[k*ADDR_W +: ADDR_W])) begin
        luh = 1'b1;
      end
      if ((rd_q != '0) && (rd_q == IF_ID_Src[k*ADDR_W +: ADDR_W])) begin
        md_rd_hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    unique case (state_q)
      StIdle, StDone: begin
        // DONE accepts a new issue directly so back-to-back MUL/DIVs skip IDLE.
        if (md_start) begin
          state_d = StBusy;
          cnt_d   = CntW'(MD_LAT - 1);
          rd_d    = md_rd;
        end else begin
          state_d = StIdle;
        end
      end
      StBusy: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    mdh         = (((state_q == StBusy) || (state_q == StDone)) && md_rd_hit) ||
                  ((state_q == StBusy) && IF_ID_IsMD);
    stall       = ~reset & (luh | mdh);
    PC_Write    = ~stall;
    IF_ID_Write = ~stall;
    ID_EX_Flush = stall;
    md_busy     = ~reset & (state_q == StBusy);
    md_wb       = ~reset & (state_q == StDone);
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed scenarios then random traffic, every cycle compared
// against a time-based reference model of forwarding, load-use and MUL/DIV occupancy.
module tb_fwd_hazard_unit;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NSRC   = 2;
  localparam int unsigned MD_LAT = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NSRC*ADDR_W-1:0] IF_ID_Src, ID_EX_Src;
  logic                   IF_ID_IsMD, ID_EX_MemRead, EX_MEM_RegWrite, MEM_WB_RegWrite, md_start;
  logic [ADDR_W-1:0]      ID_EX_Rd, EX_MEM_Rd, MEM_WB_Rd, md_rd;
  logic [NSRC*2-1:0]      Forward;
  logic                   stall, PC_Write, IF_ID_Write, ID_EX_Flush, md_busy, md_wb;

  int checks = 0;
  int errors = 0;

  // Reference model: MUL/DIV tracked as "edges since issue".
  bit               m_valid = 1'b0;
  int               m_since = 0;
  logic [ADDR_W-1:0] m_rd = '0;

  fwd_hazard_unit #(.ADDR_W(ADDR_W), .NSRC(NSRC), .MD_LAT(MD_LAT)) dut (
    .clk(clk), .reset(reset),
    .IF_ID_Src(IF_ID_Src), .IF_ID_IsMD(IF_ID_IsMD),
    .ID_EX_Src(ID_EX_Src), .ID_EX_Rd(ID_EX_Rd), .ID_EX_MemRead(ID_EX_MemRead),
    .EX_MEM_Rd(EX_MEM_Rd), .EX_MEM_RegWrite(EX_MEM_RegWrite),
    .MEM_WB_Rd(MEM_WB_Rd), .MEM_WB_RegWrite(MEM_WB_RegWrite),
    .md_start(md_start), .md_rd(md_rd),
    .Forward(Forward), .stall(stall), .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
    .ID_EX_Flush(ID_EX_Flush), .md_busy(md_busy), .md_wb(md_wb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int field(input logic [NSRC*ADDR_W-1:0] v, input int k);
    return int'((v >> (k * ADDR_W)) & ((1 << ADDR_W) - 1));
  endfunction

  function automatic logic [NSRC*2-1:0] ref_fwd();
    logic [NSRC*2-1:0] f = '0;
    for (int k = 0; k < NSRC; k++) begin
      int s = field(ID_EX_Src, k);
      if (EX_MEM_RegWrite && EX_MEM_Rd != 0 && int'(EX_MEM_Rd) == s) f[2*k +: 2] = 2'b10;
      else if (MEM_WB_RegWrite && MEM_WB_Rd != 0 && int'(MEM_WB_Rd) == s) f[2*k +: 2] = 2'b01;
    end
    return f;
  endfunction

  function automatic bit src_uses(input logic [ADDR_W-1:0] r);
    bit hit = 1'b0;
    for (int k = 0; k < NSRC; k++) if (r != 0 && field(IF_ID_Src, k) == int'(r)) hit = 1'b1;
    return hit;
  endfunction

  // Compare every output against the model, away from the clock edge.
  task automatic settle();
    bit busy, done, st;
    @(negedge clk);
    busy = !reset && m_valid && (m_since < MD_LAT);
    done = !reset && m_valid && (m_since == MD_LAT);
    st   = !reset && ((ID_EX_MemRead && src_uses(ID_EX_Rd)) ||
                      ((busy || done) && src_uses(m_rd)) || (busy && IF_ID_IsMD));
    check("Forward", 8'(Forward), 8'(ref_fwd()));
    check("stall", 8'(stall), 8'(st));
    check("PC_Write", 8'(PC_Write), 8'(!st));
    check("IF_ID_Write", 8'(IF_ID_Write), 8'(!st));
    check("ID_EX_Flush", 8'(ID_EX_Flush), 8'(st));
    check("md_busy", 8'(md_busy), 8'(busy));
    check("md_wb", 8'(md_wb), 8'(done));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_valid = 1'b0;
    end else if (md_start && (!m_valid || m_since == MD_LAT)) begin
      m_valid = 1'b1;
      m_since = 1;
      m_rd    = md_rd;
    end else if (m_valid) begin
      m_since++;
      if (m_since > MD_LAT) m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic clear_inputs();
    IF_ID_Src = '0; ID_EX_Src = '0; IF_ID_IsMD = 0; ID_EX_MemRead = 0;
    EX_MEM_RegWrite = 0; MEM_WB_RegWrite = 0; md_start = 0;
    ID_EX_Rd = '0; EX_MEM_Rd = '0; MEM_WB_Rd = '0; md_rd = '0;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    #1;
    // Reset state.
    settle();
    check("rst_fwd", 8'(Forward), 8'h00);
    check("rst_pcw", 8'(PC_Write), 8'h01);
    check("rst_busy", 8'(md_busy), 8'h00);
    tick();
    reset = 1'b0;

    // Both stages match: EX/MEM wins on both operands.
    EX_MEM_RegWrite = 1; EX_MEM_Rd = 3; MEM_WB_RegWrite = 1; MEM_WB_Rd = 3;
    ID_EX_Src = {5'd3, 5'd3};
    settle();
    check("t1_fwd", 8'(Forward), 8'h0a);
    check("t1_stall", 8'(stall), 8'h00);
    tick();

    EX_MEM_Rd = 4; MEM_WB_Rd = 7; ID_EX_Src = {5'd7, 5'd4};
    settle();
    check("t2_fwd", 8'(Forward), 8'h06);
    tick();
    EX_MEM_Rd = 0; MEM_WB_Rd = 0; ID_EX_Src = '0;
    settle();
    check("t2_r0_fwd", 8'(Forward), 8'h00);
    tick();
    clear_inputs();

    // Load-use: one stall cycle, then the bubble clears the match.
    ID_EX_MemRead = 1; ID_EX_Rd = 9; IF_ID_Src = {5'd2, 5'd9};
    settle();
    check("t3_stall", 8'(stall), 8'h01);
    check("t3_pcw", 8'(PC_Write), 8'h00);
    check("t3_flush", 8'(ID_EX_Flush), 8'h01);
    tick();
    ID_EX_MemRead = 0; ID_EX_Rd = 0;
    settle();
    check("t3_release", 8'(stall), 8'h00);
    tick();
    ID_EX_MemRead = 1; ID_EX_Rd = 0; IF_ID_Src = {5'd0, 5'd0};
    settle();
    check("t3_r0", 8'(stall), 8'h00);
    tick();
    clear_inputs();

    // MUL/DIV issue at t with dependent decode.
    md_start = 1; md_rd = 5;
    step();
    md_start = 0; IF_ID_Src = {5'd5, 5'd0};
    for (int c = 1; c <= 3; c++) begin
      settle();
      check("t4_busy", 8'(md_busy), 8'h01);
      check("t4_stall", 8'(stall), 8'h01);
      check("t4_wb_early", 8'(md_wb), 8'h00);
      tick();
    end
    settle();
    check("t4_wb", 8'(md_wb), 8'h01);
    check("t4_stall_done", 8'(stall), 8'h01);
    tick();
    settle();
    check("t4_release", 8'(stall), 8'h00);
    check("t4_wb_once", 8'(md_wb), 8'h00);
    tick();
    clear_inputs();

    // Structural MD hazard, then back-to-back issue from DONE.
    md_start = 1; md_rd = 0;
    step();
    md_start = 0; IF_ID_IsMD = 1;
    for (int c = 1; c <= 3; c++) begin
      settle();
      check("t5_stall", 8'(stall), 8'h01);
      tick();
    end
    md_start = 1; md_rd = 6;
    settle();
    check("t5_done_wb", 8'(md_wb), 8'h01);
    check("t5_done_stall", 8'(stall), 8'h00);
    tick();
    md_start = 0; IF_ID_IsMD = 0;
    settle();
    check("t5_b2b_busy", 8'(md_busy), 8'h01);
    tick();
    for (int c = 0; c < 4; c++) step();
    clear_inputs();

    // Reset mid-BUSY discards the operation.
    md_start = 1; md_rd = 8;
    step();
    md_start = 0; IF_ID_Src = {5'd8, 5'd8};
    step();
    reset = 1;
    step();
    reset = 0;
    settle();
    check("t6_busy", 8'(md_busy), 8'h00);
    check("t6_stall", 8'(stall), 8'h00);
    tick();
    for (int c = 0; c < 6; c++) begin
      settle();
      check("t6_no_wb", 8'(md_wb), 8'h00);
      tick();
    end

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NSRC; k++) begin
        IF_ID_Src[k*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 7));
        ID_EX_Src[k*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 7));
      end
      ID_EX_Rd        = ADDR_W'($urandom_range(0, 7));
      EX_MEM_Rd       = ADDR_W'($urandom_range(0, 7));
      MEM_WB_Rd       = ADDR_W'($urandom_range(0, 7));
      md_rd           = ADDR_W'($urandom_range(0, 7));
      ID_EX_MemRead   = 1'($urandom_range(0, 1));
      EX_MEM_RegWrite = 1'($urandom_range(0, 1));
      MEM_WB_RegWrite = 1'($urandom_range(0, 1));
      IF_ID_IsMD      = 1'($urandom_range(0, 3) == 0);
      md_start        = 1'($urandom_range(0, 2) == 0);
      reset           = 1'($urandom_range(0, 29) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
